// File: rtl/pe_array_pkg.sv
// Shared constants and state encoding for the PE array tile scheduler.
// Kernel geometry and weight-control encodings live here.
package pe_array_pkg;

  localparam int PE_ROWS = 3;
  localparam int KERNEL  = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLR_ALL,
    LOAD_W,
    FEED,
    WAIT,
    EMIT,
    CLR_ROW,
    DONE
  } state_t;

  localparam logic [1:0] WC_HOLD = 2'b00;
  localparam logic [1:0] WC_LOAD = 2'b01;
  localparam logic [1:0] WC_ROT  = 2'b10;

endpackage

// File: rtl/pe_row_ptr.sv
// Modulo-N wrap counter selecting the PE row that owns the next output.
// Provides synchronous clear, increment and a one-hot decode.
module pe_row_ptr #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(N - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = (ptr == PW'(i));
    end
  end

endmodule

// File: rtl/pe_array_sched.sv
// Control sequencer for the 3-row PE array over one 3x3 conv tile:
// weight load, row feed, settle wait, output drain and row clear.
module pe_array_sched
  import pe_array_pkg::*;
#(
  parameter int PE_ROWS = 3,
  parameter int PE_LAT  = 4,
  parameter int ROW_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ROW_W-1:0]   cmd_rows,
  output logic               cmd_err,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic               f_valid,
  output logic               f_ready,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [ROW_W-1:0]   o_row_idx,
  output logic [1:0]         weight_control,
  output logic [PE_ROWS-1:0] pe_rst_n,
  output logic [PE_ROWS-1:0] output_en_line,
  output logic               busy,
  output logic               done
);

  localparam int WCW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam int PW  = (PE_ROWS > 1) ? $clog2(PE_ROWS) : 1;

  state_t state, state_n;

  logic [ROW_W-1:0]   rows;
  logic [ROW_W-1:0]   rows_in;
  logic [WCW-1:0]     wait_cnt;
  logic [PW-1:0]      ptr;
  logic [PE_ROWS-1:0] ptr_oh;
  logic               cmd_acc;
  logic               cmd_ok;
  logic               f_hs;

  assign cmd_acc = cmd_ready & cmd_valid;
  assign cmd_ok  = (cmd_rows >= ROW_W'(KERNEL));
  assign f_hs    = (state == FEED) & f_valid;
  assign w_ready = (state == LOAD_W);
  assign f_ready = (state == FEED);

  pe_row_ptr #(
    .N  (PE_ROWS),
    .PW (PW)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == CLR_ALL),
    .inc    (state == CLR_ROW),
    .ptr    (ptr),
    .onehot (ptr_oh)
  );

  always_comb begin
    state_n        = state;
    weight_control = WC_HOLD;
    unique case (state)
      IDLE: begin
        if (cmd_acc && cmd_ok) state_n = CLR_ALL;
      end
      CLR_ALL: state_n = LOAD_W;
      LOAD_W: begin
        if (w_valid) begin
          weight_control = WC_LOAD;
          state_n        = FEED;
        end
      end
      FEED: begin
        if (f_valid) state_n = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          weight_control = WC_ROT;
          state_n = (rows_in >= ROW_W'(KERNEL)) ? EMIT : FEED;
        end
      end
      EMIT: begin
        if (o_ready) state_n = CLR_ROW;
      end
      CLR_ROW: state_n = (rows_in == rows) ? DONE : FEED;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs follow the state being entered, so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rows           <= '0;
      rows_in        <= '0;
      wait_cnt       <= '0;
      cmd_ready      <= 1'b0;
      cmd_err        <= 1'b0;
      o_valid        <= 1'b0;
      o_row_idx      <= '0;
      output_en_line <= '0;
      pe_rst_n       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state <= state_n;
      if (cmd_acc && cmd_ok) begin
        rows    <= cmd_rows;
        rows_in <= '0;
      end
      if (f_hs) begin
        rows_in  <= rows_in + 1'b1;
        wait_cnt <= WCW'(PE_LAT - 1);
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      cmd_ready      <= (state_n == IDLE);
      cmd_err        <= cmd_acc && !cmd_ok;
      o_valid        <= (state_n == EMIT);
      o_row_idx      <= (state_n == EMIT) ? rows_in - ROW_W'(KERNEL) : '0;
      output_en_line <= (state_n == EMIT) ? ptr_oh : '0;
      busy           <= (state_n != IDLE);
      done           <= (state_n == DONE);
      if (state_n == CLR_ALL) begin
        pe_rst_n <= '0;
      end else if (state_n == CLR_ROW) begin
        pe_rst_n <= ~ptr_oh;
      end else begin
        pe_rst_n <= '1;
      end
    end
  end

endmodule

// File: tb/tb_pe_array_sched.sv
// Directed bench for pe_array_sched: tile runs with hand-derived
// output order, row-clear masks, weight pulses and abort behaviour.
module tb_pe_array_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_rows = '0;
  logic       w_valid = 1'b0;
  logic       f_valid = 1'b0;
  logic       o_ready = 1'b0;
  logic       cmd_ready, cmd_err, w_ready, f_ready, o_valid;
  logic [7:0] o_row_idx;
  logic [1:0] weight_control;
  logic [2:0] pe_rst_n, output_en_line;
  logic       busy, done;

  always #5 clk = ~clk;

  pe_array_sched #(
    .PE_ROWS (3),
    .PE_LAT  (4),
    .ROW_W   (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_rows       (cmd_rows),
    .cmd_err        (cmd_err),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .f_valid        (f_valid),
    .f_ready        (f_ready),
    .o_valid        (o_valid),
    .o_ready        (o_ready),
    .o_row_idx      (o_row_idx),
    .weight_control (weight_control),
    .pe_rst_n       (pe_rst_n),
    .output_en_line (output_en_line),
    .busy           (busy),
    .done           (done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  int rot_cnt, load_cnt, done_cnt, err_cnt, fhs_cnt, last_fhs;
  int busy_cnt, crdy_low, stall_cnt, hold_viol, f_viol;
  int oidx_q[$], oen_q[$], prst_q[$], lat_q[$];
  logic [7:0] p_idx;
  logic [2:0] p_en;
  logic       p_stall = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (weight_control == 2'b10) begin
      rot_cnt++;
      lat_q.push_back(cyc - last_fhs);
    end
    if (weight_control == 2'b01) load_cnt++;
    if (f_valid && f_ready) begin
      fhs_cnt++;
      last_fhs = cyc;
    end
    if (o_valid && o_ready) begin
      oidx_q.push_back(int'(o_row_idx));
      oen_q.push_back(int'(output_en_line));
    end
    if (o_valid && p_stall &&
        (o_row_idx !== p_idx || output_en_line !== p_en)) hold_viol++;
    p_stall = o_valid && !o_ready;
    p_idx   = o_row_idx;
    p_en    = output_en_line;
    if (o_valid && !o_ready) stall_cnt++;
    if (f_ready && (o_valid || pe_rst_n != 3'b111)) f_viol++;
    if (done) done_cnt++;
    if (cmd_err) err_cnt++;
    if (busy) busy_cnt++;
    if (!cmd_ready) crdy_low++;
    if (pe_rst_n != 3'b111) prst_q.push_back(int'(pe_rst_n));
  end

  task automatic clr_mon();
    rot_cnt = 0; load_cnt = 0; done_cnt = 0; err_cnt = 0;
    fhs_cnt = 0; last_fhs = 0; busy_cnt = 0; crdy_low = 0;
    stall_cnt = 0; hold_viol = 0; f_viol = 0;
    oidx_q.delete(); oen_q.delete(); prst_q.delete(); lat_q.delete();
  endtask

  task automatic run_tile(input int rows, input int f_gap,
                          input int o_hold, input int abort_fhs);
    int fr;
    int ho;
    int n;
    bit ok;
    fr = 0;
    ho = 0;
    ok = 1'b0;
    clr_mon();
    cmd_rows  = rows[7:0];
    cmd_valid = 1'b1;
    w_valid   = 1'b1;
    f_valid   = (f_gap == 0);
    o_ready   = (o_hold == 0);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", 32'(ok), 1);
    for (n = 0; n < 6000; n++) begin
      @(negedge clk);
      #1;
      if (f_ready) begin
        if (f_valid) fr = 0;
        else fr++;
      end
      if (o_valid) begin
        if (o_ready) ho = 0;
        else ho++;
      end
      if (done_cnt > 0) break;
      if (abort_fhs > 0 && fhs_cnt >= abort_fhs) break;
      @(posedge clk);
      #1;
      f_valid = (fr >= f_gap);
      o_ready = (ho >= o_hold);
    end
    chk("tile_timeout", 32'(n < 6000), 1);
    f_valid = 1'b0;
    o_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input int n);
    chk("out_count", oidx_q.size(), n);
    for (int i = 0; i < n && i < oidx_q.size(); i++) begin
      chk($sformatf("out_idx%0d", i), oidx_q[i], i);
      chk($sformatf("out_en%0d", i), oen_q[i], 1 << (i % 3));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pe_rst_n", pe_rst_n, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_en_line", output_en_line, 0);
    chk("rst_wc", weight_control, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_f_ready", f_ready, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_pe_rst_n", pe_rst_n, 7);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    @(posedge clk);
    #1;

    run_tile(3, 0, 0, 0);
    chk_outs(1);
    chk("r3_prst_n", prst_q.size(), 2);
    if (prst_q.size() == 2) begin
      chk("r3_prst0", prst_q[0], 0);
      chk("r3_prst1", prst_q[1], 6);
    end
    chk("r3_done", done_cnt, 1);
    chk("r3_load", load_cnt, 1);
    chk("r3_rot", rot_cnt, 3);

    run_tile(7, 0, 0, 0);
    chk_outs(5);
    chk("r7_rot", rot_cnt, 7);
    chk("r7_load", load_cnt, 1);
    chk("r7_done", done_cnt, 1);
    chk("r7_prst_n", prst_q.size(), 6);
    if (prst_q.size() == 6) begin
      chk("r7_prst0", prst_q[0], 0);
      chk("r7_prst1", prst_q[1], 6);
      chk("r7_prst2", prst_q[2], 5);
      chk("r7_prst3", prst_q[3], 3);
      chk("r7_prst4", prst_q[4], 6);
      chk("r7_prst5", prst_q[5], 5);
    end

    clr_mon();
    cmd_rows  = 8'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("r2_err", err_cnt, 1);
    chk("r2_busy", busy_cnt, 0);
    chk("r2_cmd_ready_low", crdy_low, 0);

    run_tile(5, 0, 10, 0);
    chk_outs(3);
    chk("r5_stall", stall_cnt, 30);
    chk("r5_hold", hold_viol, 0);
    chk("r5_f_ready", f_viol, 0);
    chk("r5_done", done_cnt, 1);

    run_tile(6, 3, 0, 0);
    chk_outs(4);
    chk("r6_lat_n", lat_q.size(), 6);
    foreach (lat_q[i]) chk($sformatf("r6_lat%0d", i), lat_q[i], 4);
    chk("r6_done", done_cnt, 1);

    run_tile(5, 0, 0, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_pe_rst_n", pe_rst_n, 0);
    chk("abort_o_valid", o_valid, 0);
    @(negedge clk);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_pe_rst_n_rel", pe_rst_n, 7);
    chk("abort_no_done", done_cnt, 0);
    @(posedge clk);
    #1;

    run_tile(3, 0, 0, 0);
    chk_outs(1);
    chk("post_abort_done", done_cnt, 1);
    chk("post_abort_rot", rot_cnt, 3);

    run_tile(255, 0, 0, 0);
    chk("r255_count", oidx_q.size(), 253);
    if (oidx_q.size() == 253) begin
      chk("r255_last_idx", oidx_q[252], 252);
      chk("r255_last_en", oen_q[252], 1);
    end
    chk("r255_rot", rot_cnt, 255);
    chk("r255_done", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
